// File: rtl/fifo_reader.sv
// Burst reader: pops len_i bytes from an upstream FIFO with one-cycle read latency
// and streams them out through a two-entry skid buffer with valid/ready handshaking.
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  deliver_cnt_q, deliver_cnt_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pop;
  logic [2:0]        level;
  logic [1:0]        wr_idx;

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = head_q;
  assign m_last_o  = m_valid_o && (deliver_cnt_q == LEN_W'(1));
  assign pop       = m_valid_o && m_ready_i;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  // Bytes held or on their way after this edge; a new read may only be issued if a slot remains.
  assign level = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign fifo_rd_en_o = (state_q == RUN) && !fifo_empty_i &&
                        (issue_cnt_q != '0) && (level < 3'd2);

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d       = RUN;
            issue_cnt_d   = len_i;
            deliver_cnt_d = len_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (fifo_rd_en_o) issue_cnt_d = issue_cnt_q - LEN_W'(1);
        if (pop) begin
          deliver_cnt_d = deliver_cnt_q - LEN_W'(1);
          if (m_last_o) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // A pop shifts tail into head first, so the arriving byte lands behind anything still queued.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    if (pop) head_d = tail_q;
    wr_idx     = occ_q - {1'b0, pop};
    if (inflight_q) begin
      if (wr_idx == 2'd0) head_d = fifo_data_i;
      else                tail_d = fifo_data_i;
    end
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    inflight_d = fifo_rd_en_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: fixed cycle table, directed corner sequences and random bursts,
// all checked against a transaction-level model (byte order, 2-cycle latency, occupancy bound).
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [3:0] len_i;
  logic       busy_o;
  logic       done_o;
  logic       fifo_empty_i;
  logic       fifo_rd_en_o;
  logic [7:0] fifo_data_i;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [7:0] m_data_o;
  logic       m_last_o;

  fifo_reader #(.DATA_W(8), .LEN_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_data_i  (fifo_data_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO: data appears one cycle after the pop strobe, junk otherwise.
  logic       force_empty;
  logic [7:0] fifo_mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign fifo_empty_i = force_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en_o && !fifo_empty_i) begin
      fifo_data_i <= fifo_mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end else begin
      fifo_data_i <= 8'($urandom);
    end
  end

  // Transaction model: burst phase, bytes issued/delivered, and the cycle each issued byte becomes visible.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int blen      = 0;
  int issued    = 0;
  int delivered = 0;
  int base      = 0;
  int rd_seen   = 0;
  int arrive [0:15];

  typedef struct packed {
    logic       start;
    logic [3:0] len;
    logic       ready;
    logic       rd;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs [0:11];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic pushByte(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] l, input logic r);
    start_i   = s;
    len_i     = l;
    m_ready_i = r;
    @(negedge clk);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    logic exp_valid, exp_pop, exp_rd, exp_last;
    exp_valid = (m_state == M_RUN) && (delivered < issued) && (cyc >= arrive[delivered]);
    exp_pop   = exp_valid && m_ready_i;
    exp_rd    = (m_state == M_RUN) && !fifo_empty_i && (issued < blen) &&
                ((issued - delivered - (exp_pop ? 1 : 0)) < 2);
    exp_last  = exp_valid && (delivered == blen - 1);
    chk("busy_o", busy_o, m_state != M_IDLE);
    chk("done_o", done_o, m_state == M_DONE);
    chk("fifo_rd_en_o", fifo_rd_en_o, exp_rd);
    chk("m_valid_o", m_valid_o, exp_valid);
    chk("m_last_o", m_last_o, exp_last);
    if (exp_valid) chk("m_data_o", m_data_o, fifo_mem[base + delivered]);
    if (fifo_rd_en_o === 1'b1) rd_seen++;
    case (m_state)
      M_IDLE: begin
        if (start_i) begin
          if (len_i != 4'd0) begin
            m_state   = M_RUN;
            blen      = int'(len_i);
            issued    = 0;
            delivered = 0;
            base      = rd_ptr;
          end else begin
            m_state = M_DONE;
          end
        end
      end
      M_RUN: begin
        if (exp_rd) begin
          arrive[issued] = cyc + 2;
          issued++;
        end
        if (exp_pop) begin
          delivered++;
          if (exp_last) m_state = M_DONE;
        end
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic runCycle(input logic s, input logic [3:0] l, input logic r);
    applyStimulus(s, l, r);
    checkOutput();
    stepEdge();
  endtask

  task automatic checkZero(input string tag);
    chk({tag, " busy_o"}, busy_o, 0);
    chk({tag, " done_o"}, done_o, 0);
    chk({tag, " fifo_rd_en_o"}, fifo_rd_en_o, 0);
    chk({tag, " m_valid_o"}, m_valid_o, 0);
    chk({tag, " m_last_o"}, m_last_o, 0);
    chk({tag, " m_data_o"}, m_data_o, 0);
  endtask

  task automatic doReset();
    rst         = 1'b1;
    start_i     = 1'($urandom);
    len_i       = 4'($urandom);
    m_ready_i   = 1'($urandom);
    force_empty = 1'($urandom);
    #1;
    checkZero("reset entry");
    m_state   = M_IDLE;
    issued    = 0;
    delivered = 0;
    blen      = 0;
    @(posedge clk);
    #1;
    start_i   = 1'($urandom);
    len_i     = 4'($urandom);
    m_ready_i = 1'($urandom);
    @(negedge clk);
    checkZero("reset held");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    force_empty = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkZero("after release");
    checkOutput();
    stepEdge();
  endtask

  task automatic runUntilIdle(input bit rand_mode, input int bound);
    int n;
    n = 0;
    while (m_state != M_IDLE && n < bound) begin
      if (rand_mode) begin
        force_empty = ($urandom_range(0, 3) == 0);
        runCycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end else begin
        runCycle(1'b0, 4'd0, 1'b1);
      end
      n++;
    end
    force_empty = 1'b0;
    total++;
    if (m_state != M_IDLE) begin
      bad++;
      $display("[TB] FAIL burst timeout: still busy after %0d cycles, required idle", bound);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int rel;
    int done_rel;
    int rlen;

    vecs[0]  = '{1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) arrive[i] = 0;

    doReset();

    // Four-byte burst at full rate, then a zero-length request.
    for (int i = 0; i < 4; i++) pushByte(8'(8'hA0 + i));
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].start, vecs[i].len, vecs[i].ready);
      chk($sformatf("vec%0d rd/valid/last/done/busy", i),
          {fifo_rd_en_o, m_valid_o, m_last_o, done_o, busy_o},
          {vecs[i].rd, vecs[i].valid, vecs[i].last, vecs[i].done, vecs[i].busy});
      if (vecs[i].valid) chk($sformatf("vec%0d data", i), m_data_o, vecs[i].data);
      checkOutput();
      stepEdge();
    end

    // Consumer stalled: only two reads may be issued, head held.
    for (int i = 0; i < 8; i++) pushByte(8'(8'hB0 + i));
    rd_seen = 0;
    runCycle(1'b1, 4'd8, 1'b0);
    for (int i = 0; i < 10; i++) runCycle(1'b0, 4'd0, 1'b0);
    chk("stall rd count", rd_seen, 2);
    chk("stall head data", m_data_o, 8'hB0);
    chk("stall valid", m_valid_o, 1);
    runUntilIdle(1'b0, 40);
    chk("stall delivered", delivered, 8);

    // Upstream FIFO empty for five cycles after start.
    for (int i = 0; i < 3; i++) pushByte(8'(8'hC0 + i));
    force_empty = 1'b1;
    rd_seen = 0;
    runCycle(1'b1, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) runCycle(1'b0, 4'd0, 1'b1);
    chk("empty rd count", rd_seen, 0);
    chk("empty busy", busy_o, 1);
    chk("empty valid", m_valid_o, 0);
    force_empty = 1'b0;
    runUntilIdle(1'b0, 40);
    chk("empty delivered", delivered, 3);

    // Reset after two of six bytes, then a clean two-byte burst.
    for (int i = 0; i < 6; i++) pushByte(8'(8'hD0 + i));
    runCycle(1'b1, 4'd6, 1'b1);
    n = 0;
    while (delivered < 2 && n < 20) begin
      runCycle(1'b0, 4'd0, 1'b1);
      n++;
    end
    chk("pre-reset delivered", delivered, 2);
    doReset();
    pushByte(8'hE0);
    pushByte(8'hE1);
    runCycle(1'b1, 4'd2, 1'b1);
    rel = 0;
    done_rel = -1;
    while (m_state != M_IDLE && rel < 20) begin
      rel++;
      applyStimulus(1'b0, 4'd0, 1'b1);
      if (done_o === 1'b1 && done_rel < 0) done_rel = rel;
      checkOutput();
      stepEdge();
    end
    chk("post-reset done cycle", done_rel, 5);

    // Random bursts with random backpressure, FIFO gaps and ignored start requests.
    for (int b = 0; b < 25; b++) begin
      rlen = $urandom_range(0, 15);
      for (int i = 0; i <= rlen; i++) pushByte(8'($urandom));
      force_empty = ($urandom_range(0, 3) == 0);
      runCycle(1'b1, 4'(rlen), ($urandom_range(0, 3) != 0));
      runUntilIdle(1'b1, 300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter: DATA_W, default 8, byte width of FIFO data and stream data.
REQ-002 Parameter: LEN_W, default 4, width of the burst length request.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start_i  input  1  burst request, sampled only in IDLE.
REQ-006 Port: len_i  input  LEN_W  burst length in bytes, sampled with start_i.
REQ-007 Port: busy_o  output  1  high whenever state is not IDLE.
REQ-008 Port: done_o  output  1  one-cycle pulse at burst completion.
REQ-009 Port: fifo_empty_i  input  1  empty flag of upstream FIFO.
REQ-010 Port: fifo_rd_en_o  output  1  FIFO pop strobe; combinational.
REQ-011 Port: fifo_data_i  input  DATA_W  FIFO read data; valid exactly one cycle after fifo_rd_en_o.
REQ-012 Port: m_valid_o  output  1  stream data valid.
REQ-013 Port: m_ready_i  input  1  stream consumer ready.
REQ-014 Port: m_data_o  output  DATA_W  stream data (head of output buffer).
REQ-015 Port: m_last_o  output  1  marks final byte of burst; qualified by m_valid_o.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start_i with len_i!=0; IDLE->DONE on start_i with len_i==0; RUN->DONE on handshake of the byte with m_last_o; DONE->IDLE unconditionally after one cycle.
REQ-017 start_i SHALL be ignored outside IDLE; len_i SHALL be latched into an issue counter and a deliver counter on entry to RUN.
REQ-018 Output buffer SHALL hold 2 entries (occ 0..2); an in-flight flag SHALL be the registered value of fifo_rd_en_o.
REQ-019 fifo_rd_en_o SHALL equal: state==RUN and !fifo_empty_i and issue_cnt!=0 and (occ + inflight - pop) < 2, where pop = m_valid_o & m_ready_i.
REQ-020 Each fifo_rd_en_o SHALL decrement issue_cnt by 1; fifo_rd_en_o SHALL never assert while fifo_empty_i is high or issue_cnt is 0.
REQ-021 When inflight is high, fifo_data_i SHALL be written to the buffer tail at that clock edge; simultaneous write and pop SHALL leave occ unchanged, preserve order, and not drop data.
REQ-022 m_valid_o SHALL equal occ!=0; m_data_o SHALL be the oldest entry; it SHALL stay stable while m_valid_o=1 and m_ready_i=0.
REQ-023 Each handshake SHALL decrement deliver_cnt; m_last_o SHALL be high iff m_valid_o and deliver_cnt==1.
REQ-024 With m_ready_i held high and FIFO non-empty, throughput SHALL be one byte per cycle; first m_valid_o SHALL occur 2 cycles after first fifo_rd_en_o.
REQ-025 done_o SHALL be high for exactly the single cycle spent in DONE; busy_o SHALL be low only in IDLE.
REQ-026 FIFO going empty mid-burst SHALL stall issue without losing state; reads resume when fifo_empty_i falls.

Reset
REQ-027 On rst: state=IDLE, occ=0, inflight=0, issue_cnt=0, deliver_cnt=0; busy_o, done_o, fifo_rd_en_o, m_valid_o, m_last_o =0; m_data_o=0.
REQ-028 rst asserted mid-burst SHALL abort immediately, discard buffered and in-flight bytes, and not pulse done_o.

Verification
REQ-029 Assert rst with random inputs -> all outputs 0 during and one cycle after release.
REQ-030 FIFO holds 0xA0..0xA3, start_i with len_i=4, m_ready_i=1 -> rd_en 4 consecutive cycles from cycle after start; m_data_o A0,A1,A2,A3 on consecutive cycles 2 cycles later; m_last_o with A3; done_o one cycle after A3 handshake.
REQ-031 len_i=8, m_ready_i=0 -> exactly 2 rd_en pulses, m_data_o held at first byte; release ready -> all 8 bytes in order, none lost.
REQ-032 len_i=3, fifo_empty_i=1 for 5 cycles after start -> no rd_en, m_valid_o=0, busy_o=1; then 3 bytes delivered normally.
REQ-033 start_i with len_i=0 -> no rd_en, done_o pulse on next cycle, busy_o high that cycle only.
REQ-034 rst asserted after 2 of 6 bytes delivered -> outputs 0 immediately, no done_o; new burst len_i=2 afterwards behaves as REQ-030.
